game_event_fifo: RTL and testbench



---
 rtl/game_pkg.sv | 27 ++
 rtl/game_event_fifo_if.sv | 11 +
 rtl/game_event_fifo_sync_fifo.sv | 60 ++++++
 rtl/game_event_fifo.sv | 108 ++++++++++
 tb/tb_game_event_fifo.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the counter game stage and its event history FIFO.
package game_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        LOSE = 2'b01,
        WIN  = 2'b10,
        OVER = 2'b11
    } ev_kind_t;

    localparam logic [1:0] W_LOSER  = 2'b01;
    localparam logic [1:0] W_WINNER = 2'b10;

    localparam logic [3:0] SCORE_LIMIT = 4'd15;

    // Record header; the counter snapshot is appended below it in the FIFO word.
    typedef struct packed {
        ev_kind_t    kind;
        logic [1:0]  who;
        logic [3:0]  ordinal;
    } game_event_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/game_event_fifo_if.sv
// Valid/ready drain port of the game event FIFO.
interface game_event_fifo_if #(parameter int COUNTER_SIZE = 3);

    logic                      ev_valid;
    logic                      ev_ready;
    logic [8+COUNTER_SIZE-1:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);

endinterface

// File: rtl/game_event_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is read straight from storage.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_wr_s;
    logic             do_rd_s;

    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rd_valid = ~empty;
    assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];
    assign do_rd_s  = rd_valid & rd_ready;
    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_wr_s  = wr_en & (~full | do_rd_s);

    // Read and write pointer advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage, cleared on reset so the idle head word reads zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/game_event_fifo.sv
// Converts counter-stage outcomes into event records, buffers them, and keeps mirror scores.
module game_event_fifo
    import game_pkg::*;
#(
    parameter int COUNTER_SIZE = 3,
    parameter int DEPTH        = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    winner,
    input  logic                    loser,
    input  logic                    gameover,
    input  logic [1:0]              who,
    input  logic [COUNTER_SIZE-1:0] counter_value,
    input  logic                    clr_ovf,
    output logic [3:0]              score_win,
    output logic [3:0]              score_lose,
    output logic                    overflow,
    output logic [7:0]              drop_count,
    game_event_fifo_if.master       ev
);

    game_event_t hdr_s;
    logic        push_s;
    logic        pop_s;
    logic        drop_s;
    logic        full_s;
    logic        empty_s;
    logic [3:0]  score_win_r;
    logic [3:0]  score_lose_r;
    logic        overflow_r;
    logic [7:0]  drop_count_r;

    // Event selection: gameover absorbs any coincident win/lose, loser beats winner.
    always_comb begin
        push_s = 1'b0;
        hdr_s  = '{kind: NONE, who: 2'b00, ordinal: 4'd0};
        if (gameover) begin
            push_s        = 1'b1;
            hdr_s.kind    = OVER;
            hdr_s.who     = who;
            hdr_s.ordinal = SCORE_LIMIT;
        end else if (loser) begin
            push_s        = 1'b1;
            hdr_s.kind    = LOSE;
            hdr_s.ordinal = score_lose_r + 4'd1;
        end else if (winner) begin
            push_s        = 1'b1;
            hdr_s.kind    = WIN;
            hdr_s.ordinal = score_win_r + 4'd1;
        end else begin
            push_s = 1'b0;
        end
    end

    assign pop_s  = ~empty_s & ev.ev_ready;
    assign drop_s = push_s & full_s & ~pop_s;

    sync_fifo #(
        .WIDTH (8 + COUNTER_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (push_s),
        .wr_data  ({hdr_s, counter_value}),
        .rd_ready (ev.ev_ready),
        .rd_valid (ev.ev_valid),
        .rd_data  (ev.ev_data),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Mirror scores; they advance even when the record itself is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            score_win_r  <= 4'd0;
            score_lose_r <= 4'd0;
        end else if (gameover) begin
            score_win_r  <= 4'd0;
            score_lose_r <= 4'd0;
        end else if (loser) begin
            score_lose_r <= score_lose_r + 4'd1;
        end else if (winner) begin
            score_win_r <= score_win_r + 4'd1;
        end
    end

    // Drop tracking; a clear in the same cycle as a drop wins and the drop is not counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else if (clr_ovf) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r   <= 1'b1;
            drop_count_r <= sat_inc8(drop_count_r);
        end
    end

    assign score_win  = score_win_r;
    assign score_lose = score_lose_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_game_event_fifo.sv
// Randomised and directed scoreboard bench for game_event_fifo.
module tb_game_event_fifo;

    localparam int CS    = 3;
    localparam int DEPTH = 8;
    localparam int W     = 8 + CS;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          winner, loser, gameover, clr_ovf;
    logic [1:0]    who;
    logic [CS-1:0] counter_value;
    logic [3:0]    score_win, score_lose;
    logic          overflow;
    logic [7:0]    drop_count;

    game_event_fifo_if #(.COUNTER_SIZE(CS)) ev();

    game_event_fifo #(.COUNTER_SIZE(CS), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .winner        (winner),
        .loser         (loser),
        .gameover      (gameover),
        .who           (who),
        .counter_value (counter_value),
        .clr_ovf       (clr_ovf),
        .score_win     (score_win),
        .score_lose    (score_lose),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .ev            (ev)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of records the FIFO should hold, plus plain-integer state.
    logic [W-1:0] exp_q[$];
    int m_cnt   = 0;
    int m_sw    = 0;
    int m_sl    = 0;
    int m_ovf   = 0;
    int m_drops = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_state();
        chk("ev_valid",   int'(ev.ev_valid), (m_cnt > 0) ? 1 : 0);
        chk("score_win",  int'(score_win),   m_sw);
        chk("score_lose", int'(score_lose),  m_sl);
        chk("overflow",   int'(overflow),    m_ovf);
        chk("drop_count", int'(drop_count),  m_drops);
    endtask

    task automatic step(input bit w, input bit l, input bit g, input logic [1:0] wh,
                        input logic [CS-1:0] cv, input bit rdy, input bit clr);
        bit         pop, ev_on, drop;
        logic [1:0] k, rwho;
        int         ord;
        @(negedge clock);
        check_state();
        winner = w; loser = l; gameover = g; who = wh;
        counter_value = cv; ev.ev_ready = rdy; clr_ovf = clr;
        pop   = (m_cnt > 0) && rdy;
        ev_on = g || l || w;
        k = 2'b00; rwho = 2'b00; ord = 0;
        if (g) begin
            k = 2'b11; rwho = wh; ord = 15; m_sw = 0; m_sl = 0;
        end else if (l) begin
            k = 2'b01; m_sl = (m_sl + 1) % 16; ord = m_sl;
        end else if (w) begin
            k = 2'b10; m_sw = (m_sw + 1) % 16; ord = m_sw;
        end
        drop = ev_on && (m_cnt == DEPTH) && !pop;
        if (pop) m_cnt--;
        if (ev_on && !drop) begin
            exp_q.push_back({k, rwho, 4'(ord), cv});
            m_cnt++;
        end
        if (clr) begin
            m_ovf = 0; m_drops = 0;
        end else if (drop) begin
            m_ovf = 1;
            m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        end
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, '0, rdy, 1'b0);
    endtask

    task automatic mid_reset();
        @(negedge clock);
        check_state();
        reset_n = 1'b0;
        winner = 1'b0; loser = 1'b0; gameover = 1'b0; clr_ovf = 1'b0; ev.ev_ready = 1'b0;
        exp_q.delete();
        m_cnt = 0; m_sw = 0; m_sl = 0; m_ovf = 0; m_drops = 0;
        #1;
        chk("valid_during_reset", int'(ev.ev_valid), 0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Monitor: checks the head record whenever valid, retires it on handshake.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset_n && ev.ev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("ev_data", int'(ev.ev_data), int'(exp_q[0]));
                    if (ev.ev_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        winner = 1'b0; loser = 1'b0; gameover = 1'b0; clr_ovf = 1'b0;
        who = 2'b00; counter_value = '0; ev.ev_ready = 1'b0;
        #1;
        chk("rst_ev_valid", int'(ev.ev_valid), 0);
        chk("rst_ev_data",  int'(ev.ev_data),  0);
        chk("rst_scores",   int'({score_win, score_lose}), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_drops",    int'(drop_count), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Single loser event, then drain.
        step(1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 2);

        // Winner held at the head for five cycles with ready low.
        step(1'b1, 1'b0, 1'b0, 2'b00, 3'd7, 1'b0, 1'b0);
        idle(1'b0, 5);
        idle(1'b1, 2);

        // Gameover absorbs a simultaneous loser.
        step(1'b0, 1'b1, 1'b1, 2'b01, 3'd3, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Ten losers into a stalled FIFO, then clear the overflow.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 2'b00, 3'(i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b1);
        idle(1'b0, 1);

        // Push and pop together while full, then drain.
        step(1'b0, 1'b1, 1'b0, 2'b00, 3'd5, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 3'd6, 1'b1, 1'b0);
        idle(1'b1, DEPTH + 2);

        // Both outcomes high: loser has priority.
        step(1'b1, 1'b1, 1'b0, 2'b00, 3'd2, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Reset in the middle of a drain.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 2'b00, 3'(i), 1'b0, 1'b0);
        idle(1'b1, 1);
        mid_reset();
        idle(1'b1, 2);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 4, 2'($urandom_range(0, 3)),
                 CS'($urandom_range(0, 7)), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 3);
        end

        idle(1'b1, DEPTH + 2);
        @(negedge clock);
        check_state();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
